pcpi_fpu_ctrl: RTL and testbench

//  Sequences a shared multi-cycle single-precision FP core behind the picorv32 PCPI port.

---
 rtl/pcpi_fpu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pcpi_fpu_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_fpu_ctrl.sv
// Purpose : sequences a shared multi-cycle single-precision FP core (FADD.S/FSUB.S/FMUL.S)
//           behind the picorv32 PCPI port. Results go to the integer rd, and fflags stay sticky.
// Latency : launch 1 cycle after the accept; pcpi_ready 1 cycle after fpu_done (min 3 cycles).
//           If the core never answers, the abort fires TIMEOUT_CYCLES cycles after launch.
// Backpr. : pcpi_wait holds the CPU while the core works. No new insn is accepted until
//           pcpi_valid has been seen low after a response.
//
// Ports
//   clk, resetn               clock, synchronous active-low reset
//   pcpi_valid/insn/rs1/rs2   CPU request, held until pcpi_ready
//   pcpi_wr/rd/wait/ready     CPU response (wr and ready pulse together)
//   fpu_start/op/rm/a/b       launch pulse and latched command to the FP core
//   fpu_kill                  one-cycle abort (timeout, or the CPU withdrew the request)
//   fpu_done/result/flags     core completion, valid for one cycle
//   fflags, fflags_clr        sticky NV,DZ,OF,UF,NX accumulator and its clear (a set wins)
module pcpi_fpu_ctrl #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [2:0]  DEFAULT_FRM    = 3'b000,
  parameter logic [31:0] CANON_NAN      = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_kill,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // ---------------------------------------------------------------- decode
  logic       f7_hit;
  logic [1:0] dec_op;
  logic [2:0] dec_rm;
  logic       rm_ok;
  logic       hit;

  always_comb begin
    f7_hit = 1'b1;
    dec_op = 2'b00;
    case (pcpi_insn[31:25])
      7'b0000000: dec_op = 2'b00;
      7'b0000100: dec_op = 2'b01;
      7'b0001000: dec_op = 2'b10;
      default:    f7_hit = 1'b0;
    endcase
  end

  // rm 101/110 are reserved encodings, so the insn is left for the CPU to trap.
  assign rm_ok  = (pcpi_insn[14:12] != 3'b101) && (pcpi_insn[14:12] != 3'b110);
  assign dec_rm = (pcpi_insn[14:12] == 3'b111) ? DEFAULT_FRM : pcpi_insn[14:12];
  assign hit    = (pcpi_insn[6:0] == 7'b1010011) && f7_hit && rm_ok;

  // Register specifiers are handled by the CPU, not by this block.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // ------------------------------------------------------- abort / complete
  logic timed_out;
  logic abort_drop;
  logic abort_to;
  logic done_take;

  assign timed_out  = (timer == TIMER_LAST);
  // A withdrawn request takes priority over anything the core reports that cycle.
  assign abort_drop = ((state == S_ISSUE) || (state == S_BUSY)) && !pcpi_valid;
  assign done_take  = (state == S_BUSY) && pcpi_valid && fpu_done;
  // If done arrives on the last timer cycle, the real result is kept.
  assign abort_to   = (state == S_BUSY) && pcpi_valid && !fpu_done && timed_out;

  // The kill must react in the same cycle as done/valid so that "done wins" can hold.
  // It is therefore decoded from state and inputs, and it is masked while in reset.
  // The core shares resetn, so it needs no kill pulse then.
  assign fpu_kill = resetn && (abort_drop || abort_to);

  // ------------------------------------------------------------ sticky flags
  logic       flag_set;
  logic [4:0] flag_val;
  logic [4:0] fflags_nxt;

  assign flag_set   = done_take || abort_to;
  assign flag_val   = done_take ? fpu_flags : 5'b10000;
  // A clear and a set in the same cycle leave only the new flags.
  assign fflags_nxt = (fflags_clr ? 5'b00000 : fflags) | (flag_set ? flag_val : 5'b00000);

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      timer      <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= 32'h0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      fpu_start  <= 1'b0;
      fpu_op     <= 2'b00;
      fpu_rm     <= 3'b000;
      fpu_a      <= 32'h0;
      fpu_b      <= 32'h0;
      fflags     <= 5'b00000;
    end else begin
      fpu_start  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      fflags     <= fflags_nxt;

      case (state)
        S_IDLE: begin
          if (pcpi_valid && hit) begin
            fpu_a     <= pcpi_rs1;
            fpu_b     <= pcpi_rs2;
            fpu_op    <= dec_op;
            fpu_rm    <= dec_rm;
            fpu_start <= 1'b1;
            pcpi_wait <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Any done seen here belongs to an older, killed operation.
          timer <= '0;
          if (!pcpi_valid) begin
            pcpi_wait <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_BUSY;
          end
        end

        S_BUSY: begin
          timer <= timer + TW'(1);
          if (abort_drop) begin
            pcpi_wait <= 1'b0;
            state     <= S_IDLE;
          end else if (done_take || abort_to) begin
            pcpi_rd    <= done_take ? fpu_result : CANON_NAN;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            pcpi_wait  <= 1'b0;
            state      <= S_RESP;
          end
        end

        S_RESP: begin
          state <= S_DRAIN;
        end

        S_DRAIN: begin
          // Wait for the CPU to drop the request, so that the same insn is not issued twice.
          if (!pcpi_valid) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_fpu_ctrl.sv
// Purpose : directed checks of pcpi_fpu_ctrl (decode, handshake timing, timeout, abort,
//           sticky fflags, reset mid-operation). It uses a hand-driven FP core model.
// Ports   : none (top-level bench); DUT built with TIMEOUT_CYCLES=8, DEFAULT_FRM=3'b001.
module tb_pcpi_fpu_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_kill;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic [4:0]  fflags;
  logic        fflags_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcpi_fpu_ctrl #(
    .TIMEOUT_CYCLES(8),
    .DEFAULT_FRM   (3'b001),
    .CANON_NAN     (32'h7FC00000)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn (pcpi_insn),
    .pcpi_rs1  (pcpi_rs1),
    .pcpi_rs2  (pcpi_rs2),
    .pcpi_wr   (pcpi_wr),
    .pcpi_rd   (pcpi_rd),
    .pcpi_wait (pcpi_wait),
    .pcpi_ready(pcpi_ready),
    .fpu_start (fpu_start),
    .fpu_op    (fpu_op),
    .fpu_rm    (fpu_rm),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_kill  (fpu_kill),
    .fpu_done  (fpu_done),
    .fpu_result(fpu_result),
    .fpu_flags (fpu_flags),
    .fflags    (fflags),
    .fflags_clr(fflags_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle. Inputs are then driven at +1, and checks run #1 later, clear of the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"},     pcpi_wr,    0);
    chk({tag, "_rd"},     pcpi_rd,    0);
    chk({tag, "_wait"},   pcpi_wait,  0);
    chk({tag, "_ready"},  pcpi_ready, 0);
    chk({tag, "_start"},  fpu_start,  0);
    chk({tag, "_op"},     fpu_op,     0);
    chk({tag, "_rm"},     fpu_rm,     0);
    chk({tag, "_a"},      fpu_a,      0);
    chk({tag, "_b"},      fpu_b,      0);
    chk({tag, "_kill"},   fpu_kill,   0);
    chk({tag, "_fflags"}, fflags,     0);
  endtask

  // A full transaction. The core answers lat cycles after fpu_start; the request is accepted at T.
  task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] e_op, input logic [2:0] e_rm,
                        input int lat, input logic [31:0] res, input logic [4:0] flg,
                        input logic clr, input logic [4:0] e_fflags);
    cyc();
    pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
    #1;
    chk({tag, "_wait_T"}, pcpi_wait, 0);
    cyc(); #1;                                   // T+1: launch
    chk({tag, "_start"}, fpu_start, 1);
    chk({tag, "_wait"},  pcpi_wait, 1);
    chk({tag, "_op"},    fpu_op,    e_op);
    chk({tag, "_rm"},    fpu_rm,    e_rm);
    chk({tag, "_a"},     fpu_a,     a);
    chk({tag, "_b"},     fpu_b,     b);
    for (int i = 1; i < lat; i++) begin
      cyc(); #1;
      chk({tag, "_busy_ready"}, pcpi_ready, 0);
      chk({tag, "_busy_kill"},  fpu_kill,   0);
    end
    cyc();
    fpu_done = 1'b1; fpu_result = res; fpu_flags = flg; fflags_clr = clr;
    #1;
    chk({tag, "_done_kill"},  fpu_kill,   0);
    chk({tag, "_done_ready"}, pcpi_ready, 0);
    cyc();
    fpu_done = 1'b0; fpu_result = 32'h0; fpu_flags = 5'b0; fflags_clr = 1'b0;
    #1;
    chk({tag, "_ready"},  pcpi_ready, 1);
    chk({tag, "_wr"},     pcpi_wr,    1);
    chk({tag, "_rd"},     pcpi_rd,    res);
    chk({tag, "_wait_r"}, pcpi_wait,  0);
    chk({tag, "_fflags"}, fflags,     e_fflags);
    cyc();
    pcpi_valid = 1'b0;
    #1;
    chk({tag, "_ready_pulse"}, pcpi_ready, 0);
    chk({tag, "_a_hold"},      fpu_a,      a);
    cyc();
  endtask

  task automatic run_miss(input string tag, input logic [31:0] insn, input int ncyc);
    logic seen;
    seen = 1'b0;
    pcpi_valid = 1'b1; pcpi_insn = insn;
    for (int i = 0; i < ncyc; i++) begin
      cyc(); #1;
      seen = seen | pcpi_wait | pcpi_ready | pcpi_wr | fpu_start;
    end
    chk(tag, seen, 0);
    pcpi_valid = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] i_fmul, i_fsub, i_fadd, i_rm101;
    i_fmul  = 32'h10310253;
    i_fsub  = {7'b0000100, 5'd3, 5'd2, 3'b111, 5'd4, 7'b1010011};
    i_fadd  = {7'b0000000, 5'd3, 5'd2, 3'b010, 5'd4, 7'b1010011};
    i_rm101 = {7'b0000000, 5'd3, 5'd2, 3'b101, 5'd4, 7'b1010011};

    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'h0; pcpi_rs1 = 32'h0; pcpi_rs2 = 32'h0;
    fpu_done = 1'b0; fpu_result = 32'h0; fpu_flags = 5'b0; fflags_clr = 1'b0;
    repeat (3) cyc();
    chk_all_zero("reset");
    resetn = 1'b1;
    cyc();

    // FMUL 2.0*3.0, core latency 3: start T+1, ready T+5.
    run_op("fmul", i_fmul, 32'h40000000, 32'h40400000, 2'b10, 3'b000, 3,
           32'h40C00000, 5'b00000, 1'b0, 5'b00000);
    // FSUB with dynamic rm resolves to DEFAULT_FRM=001.
    run_op("fsub", i_fsub, 32'h3F800000, 32'h3F000000, 2'b01, 3'b001, 2,
           32'h3F000000, 5'b00001, 1'b0, 5'b00001);
    // FADD at minimum latency; the flags accumulate.
    run_op("fadd", i_fadd, 32'h3F800000, 32'h3F800000, 2'b00, 3'b010, 1,
           32'h40000000, 5'b00100, 1'b0, 5'b00101);

    run_miss("miss_fdiv", 32'h18310253, 100);
    run_miss("miss_mul",  32'h02310233, 100);
    run_miss("miss_rm101", i_rm101, 20);

    // Timeout: no core response, so the kill fires at start+8 and the result is the canonical NaN.
    cyc();
    pcpi_valid = 1'b1; pcpi_insn = i_fmul; pcpi_rs1 = 32'h1; pcpi_rs2 = 32'h2;
    cyc(); #1;
    chk("to_start", fpu_start, 1);
    for (int k = 1; k < 8; k++) begin
      cyc(); #1;
      chk("to_early_kill", fpu_kill, 0);
    end
    cyc(); #1;
    chk("to_kill", fpu_kill, 1);
    cyc(); #1;
    chk("to_kill_pulse", fpu_kill,   0);
    chk("to_ready",      pcpi_ready, 1);
    chk("to_wr",         pcpi_wr,    1);
    chk("to_rd",         pcpi_rd,    32'h7FC00000);
    chk("to_fflags",     fflags,     5'b10101);
    cyc();
    pcpi_valid = 1'b0;
    cyc();

    // The request is withdrawn 2 cycles after start, and a late done is then ignored.
    cyc();
    pcpi_valid = 1'b1; pcpi_insn = i_fmul; pcpi_rs1 = 32'h5; pcpi_rs2 = 32'h6;
    cyc(); #1;
    chk("drop_start", fpu_start, 1);
    cyc();
    cyc();
    pcpi_valid = 1'b0;
    #1;
    chk("drop_kill", fpu_kill, 1);
    cyc(); #1;
    chk("drop_kill_pulse", fpu_kill,   0);
    chk("drop_wait",       pcpi_wait,  0);
    chk("drop_ready",      pcpi_ready, 0);
    cyc();
    fpu_done = 1'b1; fpu_result = 32'hDEADBEEF; fpu_flags = 5'b11111;
    cyc();
    fpu_done = 1'b0; fpu_result = 32'h0; fpu_flags = 5'b0;
    #1;
    chk("stale_ready",  pcpi_ready, 0);
    chk("stale_fflags", fflags,     5'b10101);
    chk("stale_rd",     pcpi_rd,    32'h7FC00000);
    run_op("after_drop", i_fadd, 32'h40000000, 32'h40000000, 2'b00, 3'b010, 2,
           32'h40800000, 5'b00000, 1'b0, 5'b10101);

    // A done in the ISSUE cycle is stale and must not complete the insn.
    cyc();
    pcpi_valid = 1'b1; pcpi_insn = i_fadd; pcpi_rs1 = 32'h3F000000; pcpi_rs2 = 32'h3F000000;
    cyc();
    fpu_done = 1'b1; fpu_result = 32'hDEADBEEF; fpu_flags = 5'b11111;
    #1;
    chk("iss_start", fpu_start, 1);
    cyc();
    fpu_done = 1'b0; fpu_result = 32'h0; fpu_flags = 5'b0;
    #1;
    chk("iss_ready", pcpi_ready, 0);
    cyc();
    fpu_done = 1'b1; fpu_result = 32'h3F800000; fpu_flags = 5'b01000;
    cyc();
    fpu_done = 1'b0; fpu_result = 32'h0; fpu_flags = 5'b0;
    #1;
    chk("iss_ok_ready",  pcpi_ready, 1);
    chk("iss_ok_rd",     pcpi_rd,    32'h3F800000);
    chk("iss_ok_fflags", fflags,     5'b11101);
    cyc();
    pcpi_valid = 1'b0;
    cyc();

    // A plain clear, then a clear coincident with done: only the new flags remain.
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    #1;
    chk("clr_fflags", fflags, 5'b00000);
    run_op("pre_clr", i_fmul, 32'h40000000, 32'h40000000, 2'b10, 3'b000, 1,
           32'h40800000, 5'b00010, 1'b0, 5'b00010);
    run_op("clr_done", i_fmul, 32'h3F800000, 32'h40000000, 2'b10, 3'b000, 1,
           32'h40000000, 5'b00001, 1'b1, 5'b00001);

    // Reset during BUSY: everything reads zero after the next edge, with no kill pulse.
    cyc();
    pcpi_valid = 1'b1; pcpi_insn = i_fmul; pcpi_rs1 = 32'h7; pcpi_rs2 = 32'h8;
    cyc(); #1;
    chk("rst_start", fpu_start, 1);
    cyc();
    resetn = 1'b0;
    #1;
    chk("rst_kill_low", fpu_kill, 0);
    cyc(); #1;
    chk_all_zero("rst_mid");
    resetn = 1'b1; pcpi_valid = 1'b0;
    cyc();

    // Done on the last timer cycle wins over the timeout: no kill and no NV.
    run_op("done_at_to", i_fmul, 32'h40400000, 32'h40400000, 2'b10, 3'b000, 8,
           32'h41100000, 5'b00000, 1'b0, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
